// File: rtl/reg_file_16x16.sv
// Sixteen-entry general-purpose register file: two registered read ports and
// one synchronous write port, with same-cycle write-to-read bypass.
module reg_file_16x16 #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataA,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RdValid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic             wr_allowed_s;
  logic [WIDTH-1:0] next_a_s;
  logic [WIDTH-1:0] next_b_s;

  // Effective read value: hardwired zero first, then bypass, then storage.
  function automatic logic [WIDTH-1:0] eff_val(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [WIDTH-1:0]  wr_data
  );
    logic [WIDTH-1:0] val;
    if ((ZERO_REG != 0) && (addr == ADDR_ZERO)) begin
      val = DATA_ZERO;
    end else if (wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write qualification and next read-port values (bypass lives only here).
  always_comb begin
    wr_allowed_s = 1'b0;
    next_a_s     = DATA_ZERO;
    next_b_s     = DATA_ZERO;
    if ((ZERO_REG != 0) && (WrAddr == ADDR_ZERO)) begin
      wr_allowed_s = 1'b0;
    end else begin
      wr_allowed_s = WrEn;
    end
    next_a_s = eff_val(RdAddrA, regs_r[RdAddrA], WrEn, WrAddr, WrData);
    next_b_s = eff_val(RdAddrB, regs_r[RdAddrB], WrEn, WrAddr, WrData);
  end

  // Register storage update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (wr_allowed_s) begin
      regs_r[WrAddr] <= WrData;
    end
  end

  // Registered read ports: capture on RdEn, hold data otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RdDataA <= DATA_ZERO;
      RdDataB <= DATA_ZERO;
      RdValid <= 1'b0;
    end else if (RdEn) begin
      RdDataA <= next_a_s;
      RdDataB <= next_b_s;
      RdValid <= 1'b1;
    end else begin
      RdValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_16x16.sv
// Self-checking bench for reg_file_16x16: one instance with R0 hardwired to
// zero and one with R0 as an ordinary register, checked against a scoreboard.
module tb_reg_file_16x16;

  logic        Clk;
  logic        Reset_n;
  logic        WrEn;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic        RdEn;
  logic [3:0]  RdAddrA;
  logic [3:0]  RdAddrB;
  logic [15:0] a1, b1, a0, b0;
  logic        v1, v0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] a1;
    logic [15:0] b1;
    logic [15:0] a0;
    logic [15:0] b0;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last;
  logic [15:0] mem1 [16];
  logic [15:0] mem0 [16];

  reg_file_16x16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(a1), .RdDataB(b1), .RdValid(v1)
  );

  reg_file_16x16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(a0), .RdDataB(b0), .RdValid(v0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_eff(input bit zr, input logic [3:0] a);
    if (zr && a == 4'd0) return 16'h0000;
    if (WrEn && WrAddr == a) return WrData;
    return zr ? mem1[a] : mem0[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 16'h0000;
      mem0[i] = 16'h0000;
    end
    last = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sb_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a1"}, a1, 16'h0000);
    chk({tag, "_b1"}, b1, 16'h0000);
    chk({tag, "_a0"}, a0, 16'h0000);
    chk({tag, "_b0"}, b0, 16'h0000);
    chk({tag, "_v1"}, {15'd0, v1}, 16'h0000);
    chk({tag, "_v0"}, {15'd0, v0}, 16'h0000);
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic tick(input string tag);
    exp_t e;
    logic rd;
    rd = RdEn;
    if (rd) begin
      e.a1 = model_eff(1'b1, RdAddrA);
      e.b1 = model_eff(1'b1, RdAddrB);
      e.a0 = model_eff(1'b0, RdAddrA);
      e.b0 = model_eff(1'b0, RdAddrB);
      sb_q.push_back(e);
    end
    if (WrEn) begin
      mem0[WrAddr] = WrData;
      if (WrAddr != 4'd0) mem1[WrAddr] = WrData;
    end
    @(posedge Clk);
    #1;
    chk({tag, "_v1"}, {15'd0, v1}, {15'd0, rd});
    chk({tag, "_v0"}, {15'd0, v0}, {15'd0, rd});
    if (rd) begin
      if (sb_q.size() == 0) begin
        miscompares++;
        $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb_q.size());
      end else begin
        last = sb_q.pop_front();
      end
    end
    chk({tag, "_a1"}, a1, last.a1);
    chk({tag, "_b1"}, b1, last.b1);
    chk({tag, "_a0"}, a0, last.a0);
    chk({tag, "_b0"}, b0, last.b0);
  endtask

  task automatic set_in(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic re, input logic [3:0] ra, input logic [3:0] rb);
    WrEn = we; WrAddr = wa; WrData = wd; RdEn = re; RdAddrA = ra; RdAddrB = rb;
  endtask

  initial begin
    Reset_n = 1'b0;
    set_in(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_zero("reset_init");
    Reset_n = 1'b1;

    // Write then read, then hold.
    set_in(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd0); tick("wr_r3");
    set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd0); tick("rd_r3");
    set_in(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0); tick("hold");

    // Bypass on both ports.
    set_in(1'b1, 4'd7, 16'h1111, 1'b0, 4'd0, 4'd0); tick("wr_r7");
    set_in(1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 4'd7); tick("bypass_r7");
    set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd3); tick("rd_r7_after");

    // Zero register: dut1 reads 0, dut0 reads back the write.
    set_in(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0); tick("wr_r0");
    set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0); tick("rd_r0");
    set_in(1'b1, 4'd0, 16'hAAAA, 1'b1, 4'd0, 4'd0); tick("bypass_r0");

    // Streaming.
    for (int i = 1; i < 16; i++) begin
      set_in(1'b1, 4'(i), 16'(16'h0101 * i), 1'b0, 4'd0, 4'd0);
      tick("stream_wr");
    end
    for (int i = 1; i < 16; i++) begin
      set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 4'(16 - i));
      tick("stream_rd");
    end
    set_in(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0); tick("stream_end");

    // Reset mid-operation, between a write edge and a read edge.
    set_in(1'b1, 4'd9, 16'h5A5A, 1'b1, 4'd9, 4'd5); tick("pre_rst");
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    #1;
    Reset_n = 1'b1;
    set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd5); tick("post_rst_r5");
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 4'(15 - i));
      tick("post_rst_all");
    end

    // Randomized traffic, biased towards address collisions for bypass.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      set_in(1'($urandom_range(0, 1)), wa, 16'($urandom),
             1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
